// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI master clock generator.
package spi_pkg;

    // Frame sequencing states; LEAD and TRAIL are only reachable when the
    // setup/hold guard is compiled in.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LEAD   = 2'd1,
        ST_TOGGLE = 2'd2,
        ST_TRAIL  = 2'd3
    } clkgen_state_t;

    // Width of the SCLK edge counter: it must hold 0..2*frame_bits.
    function automatic int spi_edge_cnt_w(input int frame_bits);
        return $clog2(2 * frame_bits + 1);
    endfunction

    // Edge counter width for the default 8-bit frame.
    localparam int SPI_EDGE_CNT_W = spi_edge_cnt_w(8);

endpackage

// File: rtl/spi_div_counter.sv
// Loadable down counter: emits a one-cycle tick when it reaches zero and
// reloads itself with reload_val in that same cycle.
module spi_div_counter #(
    parameter int WIDTH = 8
) (
    input  logic             pclk,
    input  logic             presetn,
    input  logic             load,
    input  logic             enable,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] reload_val,
    output logic             tick
);

    logic [WIDTH-1:0] cnt;

    assign tick = enable && (cnt == '0);

    // Count down while enabled; an explicit load always wins.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (enable) begin
            cnt <= (cnt == '0) ? reload_val : cnt - WIDTH'(1);
        end
    end

endmodule

// File: rtl/spi_clk_gen.sv
// SPI master serial-clock generator. One start produces a frame of
// 2*FRAME_BITS SCLK edges plus pclk-domain sample/transmit/finish strobes.
// Optional setup/hold half-periods around the frame are enabled by defining
// the macro SPI_CLKGEN_GUARD_EN.
//
// Handshake: start is a request sampled only while idle (busy=0 or the
// transfer_finish cycle); requests seen while busy are dropped, nothing
// is queued.
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int DIV_WIDTH  = 8,
    parameter int FRAME_BITS = 8
) (
    input  logic                 pclk,
    input  logic                 presetn,
    input  logic                 start,
    input  logic                 cpol,
    input  logic                 cpha,
    input  logic [DIV_WIDTH-1:0] clk_div,
    output logic                 sclk_out,
    output logic                 busy,
    output logic                 sample_edge,
    output logic                 transmit_edge,
    output logic                 transfer_finish
);

    localparam int EDGE_W = spi_edge_cnt_w(FRAME_BITS);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * FRAME_BITS);

`ifdef SPI_CLKGEN_GUARD_EN
    localparam bit GUARD_EN = 1'b1;
`else
    localparam bit GUARD_EN = 1'b0;
`endif

    clkgen_state_t        state, state_d;
    logic [EDGE_W-1:0]    k, k_d, edge_num;
    logic                 cap_cpol, cap_cpha;
    logic [DIV_WIDTH-1:0] cap_div;
    logic                 accept, tick;
    logic                 sclk_d, busy_d, sample_d, transmit_d, finish_d;

    assign accept   = (state == ST_IDLE) && start;
    assign edge_num = k + EDGE_W'(1);

    spi_div_counter #(
        .WIDTH (DIV_WIDTH)
    ) u_div (
        .pclk       (pclk),
        .presetn    (presetn),
        .load       (accept),
        .enable     (state != ST_IDLE),
        .load_val   (clk_div),
        .reload_val (cap_div),
        .tick       (tick)
    );

    // FSM state register.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state and next values of the registered outputs.
    always_comb begin
        state_d    = state;
        k_d        = k;
        sclk_d     = sclk_out;
        sample_d   = 1'b0;
        transmit_d = 1'b0;
        finish_d   = 1'b0;
        case (state)
            ST_IDLE: begin
                sclk_d = cpol;
                k_d    = '0;
                if (start) begin
                    // With cpha=0 the first MOSI bit must be on the line
                    // before edge 1 samples it.
                    transmit_d = !cpha;
                    state_d    = GUARD_EN ? ST_LEAD : ST_TOGGLE;
                end
            end
            ST_LEAD: begin
                if (tick) begin
                    state_d = ST_TOGGLE;
                end
            end
            ST_TOGGLE: begin
                if (tick) begin
                    sclk_d = ~sclk_out;
                    k_d    = edge_num;
                    if (cap_cpha) begin
                        transmit_d = edge_num[0];
                        sample_d   = ~edge_num[0];
                    end else begin
                        sample_d   = edge_num[0];
                        transmit_d = ~edge_num[0] && (edge_num != LAST_EDGE);
                    end
                    if (edge_num == LAST_EDGE) begin
                        sclk_d   = cap_cpol;
                        state_d  = GUARD_EN ? ST_TRAIL : ST_IDLE;
                        finish_d = !GUARD_EN;
                    end
                end
            end
            ST_TRAIL: begin
                if (tick) begin
                    state_d  = ST_IDLE;
                    finish_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Output, edge-counter and captured-setting registers.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            k               <= '0;
            sclk_out        <= 1'b0;
            busy            <= 1'b0;
            sample_edge     <= 1'b0;
            transmit_edge   <= 1'b0;
            transfer_finish <= 1'b0;
            cap_cpol        <= 1'b0;
            cap_cpha        <= 1'b0;
            cap_div         <= '0;
        end else begin
            k               <= k_d;
            sclk_out        <= sclk_d;
            busy            <= busy_d;
            sample_edge     <= sample_d;
            transmit_edge   <= transmit_d;
            transfer_finish <= finish_d;
            if (accept) begin
                cap_cpol <= cpol;
                cap_cpha <= cpha;
                cap_div  <= clk_div;
            end
        end
    end

endmodule
